// File: rtl/sha256_message_padder.sv
// SHA-256 message padder: input stage of the SHA-256 core.
//
// Accepts the message one byte per cycle and applies FIPS 180-4 padding: a 0x80 marker,
// zero fill and a 64-bit big-endian bit length. Complete 512-bit blocks go out as sixteen
// 32-bit words over a valid/ready handshake, and the final block of each message is flagged.
//
// Ports:
//   clk_i             clock; all state updates on the rising edge
//   rst_ni            asynchronous active-low reset
//   load_enable_i     input_data_i holds a valid message byte
//   input_complete_i  end of message (level, held until sampled)
//   input_data_i      message byte
//   input_ready_o     padder accepts a byte / input_complete_i this cycle
//   word_valid_o      word_data_o holds a valid block word
//   word_ready_i      compression stage accepts the word
//   word_data_o       block word, first message byte in [31:24]
//   word_index_o      word position within the block, 0..15
//   block_last_o      current block is the final block of the message
//   msg_done_o        one-cycle pulse after the last word of the last block is accepted
module sha256_message_padder #(
  parameter int unsigned LenWidth = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_enable_i,
  input  logic        input_complete_i,
  input  logic [7:0]  input_data_i,
  output logic        input_ready_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_data_o,
  output logic [3:0]  word_index_o,
  output logic        block_last_o,
  output logic        msg_done_o
);

  typedef enum logic [2:0] {
    StLoad,
    StEmit,
    StEmitPad,
    StEmitLen,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          fill_q, fill_d;
  logic [LenWidth-1:0] cnt_q, cnt_d;
  logic [3:0]          idx_q, idx_d;
  // input_complete arrived together with the 64th byte of a block: the full data block
  // must go out first, then a pad block starting at fill position 0.
  logic                pend_q, pend_d;
  logic [7:0]          blk_q [64];

  logic        byte_xfer;
  logic        word_xfer;
  logic        last_word;
  logic        short_pad;
  logic [63:0] len_bits;
  logic [31:0] emit_word;
  logic [31:0] pad_word;

  assign input_ready_o = (state_q == StLoad);
  assign msg_done_o    = (state_q == StDone);
  assign word_index_o  = idx_q;
  assign byte_xfer     = load_enable_i && input_ready_o;
  assign word_xfer     = word_valid_o && word_ready_i;
  assign last_word     = (idx_q == 4'd15);
  // Marker position leaves room for the length field in the same block.
  assign short_pad     = (fill_q <= 6'd55);
  assign len_bits      = {61'(cnt_q), 3'b000};

  // Block buffer: only written in LOAD, so words stay stable while a block is emitted.
  always_ff @(posedge clk_i) begin
    if (byte_xfer) begin
      blk_q[fill_q] <= input_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StLoad;
      fill_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    unique case (state_q)
      StLoad: begin
        if (load_enable_i) begin
          fill_d = fill_q + 6'd1;
          cnt_d  = cnt_q + LenWidth'(1);
        end
        if (load_enable_i && (fill_q == 6'd63)) begin
          state_d = StEmit;
          pend_d  = input_complete_i;
        end else if (input_complete_i) begin
          state_d = StEmitPad;
        end
      end
      StEmit: begin
        if (word_xfer) begin
          idx_d = idx_q + 4'd1;
          if (last_word) begin
            state_d = pend_q ? StEmitPad : StLoad;
            pend_d  = 1'b0;
          end
        end
      end
      StEmitPad: begin
        if (word_xfer) begin
          idx_d = idx_q + 4'd1;
          if (last_word) begin
            state_d = short_pad ? StDone : StEmitLen;
          end
        end
      end
      StEmitLen: begin
        if (word_xfer) begin
          idx_d = idx_q + 4'd1;
          if (last_word) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StLoad;
        fill_d  = '0;
        cnt_d   = '0;
      end
      default: state_d = StLoad;
    endcase
  end

  // Per-byte view of the current word: raw buffer for data blocks, and
  // message / 0x80 marker / zero fill around fill position for the pad block.
  always_comb begin
    emit_word = '0;
    pad_word  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      emit_word[8*(3-k) +: 8] = blk_q[{idx_q, 2'(k)}];
      if ({idx_q, 2'(k)} < fill_q) begin
        pad_word[8*(3-k) +: 8] = blk_q[{idx_q, 2'(k)}];
      end else if ({idx_q, 2'(k)} == fill_q) begin
        pad_word[8*(3-k) +: 8] = 8'h80;
      end
    end
  end

  always_comb begin
    word_valid_o = 1'b0;
    word_data_o  = '0;
    block_last_o = 1'b0;
    unique case (state_q)
      StEmit: begin
        word_valid_o = 1'b1;
        word_data_o  = emit_word;
      end
      StEmitPad: begin
        word_valid_o = 1'b1;
        block_last_o = short_pad;
        if (short_pad && (idx_q == 4'd14)) begin
          word_data_o = len_bits[63:32];
        end else if (short_pad && (idx_q == 4'd15)) begin
          word_data_o = len_bits[31:0];
        end else begin
          word_data_o = pad_word;
        end
      end
      StEmitLen: begin
        word_valid_o = 1'b1;
        block_last_o = 1'b1;
        if (idx_q == 4'd14) begin
          word_data_o = len_bits[63:32];
        end else if (idx_q == 4'd15) begin
          word_data_o = len_bits[31:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha256_message_padder.sv
// Self-checking bench for sha256_message_padder: random and directed messages are padded by a
// queue-based reference model and compared word by word against the DUT output stream.
module tb_sha256_message_padder;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];
  typedef bit          bit_q_t[$];

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        load_enable_i = 1'b0;
  logic        input_complete_i = 1'b0;
  logic [7:0]  input_data_i = 8'h00;
  logic        input_ready_o;
  logic        word_valid_o;
  logic        word_ready_i = 1'b0;
  logic [31:0] word_data_o;
  logic [3:0]  word_index_o;
  logic        block_last_o;
  logic        msg_done_o;

  int n_cmp = 0;
  int n_err = 0;
  word_q_t got_w;

  always #5 clk_i = ~clk_i;

  sha256_message_padder #(
    .LenWidth(32)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .load_enable_i   (load_enable_i),
    .input_complete_i(input_complete_i),
    .input_data_i    (input_data_i),
    .input_ready_o   (input_ready_o),
    .word_valid_o    (word_valid_o),
    .word_ready_i    (word_ready_i),
    .word_data_o     (word_data_o),
    .word_index_o    (word_index_o),
    .block_last_o    (block_last_o),
    .msg_done_o      (msg_done_o)
  );

  // Reference padding: append 0x80, zero-fill to 56 mod 64, append 64-bit bit length.
  function automatic void ref_pad(input byte_q_t msg, output word_q_t w, output bit_q_t last);
    byte_q_t     p;
    logic [63:0] bits;
    bits = 64'(msg.size()) * 64'd8;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    w = {};
    last = {};
    for (int i = 0; i < p.size(); i += 4) begin
      w.push_back({p[i], p[i+1], p[i+2], p[i+3]});
      last.push_back(i >= p.size() - 64);
    end
  endfunction

  task automatic wait_accept(input string what);
    bit taken = 1'b0;
    for (int c = 0; c < 4000 && !taken; c++) begin
      taken = input_ready_o;
      @(negedge clk_i);
    end
    if (!taken) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_accept: input_ready=%b, required 1 within budget", what, input_ready_o);
    end
  endtask

  task automatic drive_msg(input byte_q_t msg, input bit combine);
    for (int i = 0; i < msg.size(); i++) begin
      load_enable_i    = 1'b1;
      input_data_i     = msg[i];
      input_complete_i = combine && (i == msg.size() - 1);
      wait_accept("byte");
    end
    if (!combine || msg.size() == 0) begin
      load_enable_i    = 1'b0;
      input_complete_i = 1'b1;
      wait_accept("complete");
    end
    load_enable_i    = 1'b0;
    input_complete_i = 1'b0;
  endtask

  task automatic collect(input string name, input word_q_t exp_w, input bit_q_t exp_l,
                         input bit bp);
    int          got = 0;
    bit          stalled = 1'b0;
    bit          r;
    logic [31:0] h_data;
    logic [3:0]  h_idx;
    logic        h_last;
    got_w = {};
    word_ready_i = 1'b0;
    for (int c = 0; c < 6000 && got < exp_w.size(); c++) begin
      @(negedge clk_i);
      if (stalled) begin
        n_cmp++;
        if (word_valid_o !== 1'b1 || word_data_o !== h_data || word_index_o !== h_idx ||
            block_last_o !== h_last) begin
          n_err++;
          $display("FAIL %s stall_hold: got v=%b d=%h i=%0d l=%b, required v=1 d=%h i=%0d l=%b",
                   name, word_valid_o, word_data_o, word_index_o, block_last_o,
                   h_data, h_idx, h_last);
        end
      end
      stalled = 1'b0;
      if (!bp && (got % 16 != 0)) begin
        n_cmp++;
        if (word_valid_o !== 1'b1) begin
          n_err++;
          $display("FAIL %s burst: word_valid=%b mid-block at word %0d, required 1",
                   name, word_valid_o, got);
        end
      end
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      word_ready_i = r;
      if (word_valid_o === 1'b1) begin
        n_cmp++;
        if (input_ready_o !== 1'b0) begin
          n_err++;
          $display("FAIL %s ready_in_emit: input_ready=%b, required 0", name, input_ready_o);
        end
        if (r) begin
          n_cmp++;
          if (word_data_o !== exp_w[got] || word_index_o !== 4'(got % 16) ||
              block_last_o !== exp_l[got]) begin
            n_err++;
            $display("FAIL %s word%0d: got d=%h i=%0d l=%b, required d=%h i=%0d l=%b",
                     name, got, word_data_o, word_index_o, block_last_o,
                     exp_w[got], 4'(got % 16), exp_l[got]);
          end
          got_w.push_back(word_data_o);
          got++;
        end else begin
          stalled = 1'b1;
          h_data  = word_data_o;
          h_idx   = word_index_o;
          h_last  = block_last_o;
        end
      end
    end
    if (got < exp_w.size()) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: got %0d words, required %0d", name, got, exp_w.size());
      word_ready_i = 1'b0;
    end else begin
      @(negedge clk_i);
      word_ready_i = 1'b0;
      n_cmp++;
      if (msg_done_o !== 1'b1 || input_ready_o !== 1'b0 || word_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL %s done_pulse: got done=%b rdy=%b v=%b, required 1 0 0",
                 name, msg_done_o, input_ready_o, word_valid_o);
      end
      @(negedge clk_i);
      n_cmp++;
      if (msg_done_o !== 1'b0 || input_ready_o !== 1'b1) begin
        n_err++;
        $display("FAIL %s after_done: got done=%b rdy=%b, required 0 1",
                 name, msg_done_o, input_ready_o);
      end
    end
  endtask

  task automatic run_msg(input string name, input byte_q_t msg, input bit bp, input bit combine);
    word_q_t ew;
    bit_q_t  el;
    ref_pad(msg, ew, el);
    fork
      drive_msg(msg, combine);
      collect(name, ew, el, bp);
    join
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (input_ready_o !== 1'b1 || word_valid_o !== 1'b0 || msg_done_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s ctrl: got rdy=%b v=%b done=%b, required 1 0 0",
               name, input_ready_o, word_valid_o, msg_done_o);
    end
    n_cmp++;
    if (word_data_o !== 32'h0 || word_index_o !== 4'd0 || block_last_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s data: got d=%h i=%0d l=%b, required 0 0 0",
               name, word_data_o, word_index_o, block_last_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_go_irish(input string name, input bit bp);
    byte_q_t     msg;
    logic [31:0] exp [16];
    msg = '{8'h47, 8'h6F, 8'h20, 8'h49, 8'h72, 8'h69, 8'h73, 8'h68, 8'h21};
    foreach (exp[i]) exp[i] = 32'h0;
    exp[0]  = 32'h476F2049;
    exp[1]  = 32'h72697368;
    exp[2]  = 32'h21800000;
    exp[15] = 32'h00000048;
    run_msg(name, msg, bp, 1'b0);
    n_cmp++;
    if (got_w.size() != 16) begin
      n_err++;
      $display("FAIL %s count: got %0d words, required 16", name, got_w.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (got_w[i] !== exp[i]) begin
          n_err++;
          $display("FAIL %s const_w%0d: got %h, required %h", name, i, got_w[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_empty();
    byte_q_t msg;
    msg = {};
    run_msg("empty", msg, 1'b0, 1'b0);
    n_cmp++;
    if (got_w.size() != 16 || got_w[0] !== 32'h80000000 || got_w[15] !== 32'h0) begin
      n_err++;
      $display("FAIL empty const: got n=%0d w0=%h, required 16 80000000", got_w.size(),
               (got_w.size() > 0) ? got_w[0] : 32'hx);
    end
  endtask

  task automatic test_56_bytes();
    byte_q_t msg;
    msg = {};
    for (int i = 0; i < 56; i++) msg.push_back(8'h61);
    run_msg("a56", msg, 1'b0, 1'b0);
    n_cmp++;
    if (got_w.size() != 32 || got_w[14] !== 32'h80000000 || got_w[31] !== 32'h000001C0) begin
      n_err++;
      $display("FAIL a56 const: got n=%0d, required 32 words w14=80000000 w31=000001c0",
               got_w.size());
    end
  endtask

  task automatic test_64_zero();
    byte_q_t msg;
    msg = {};
    for (int i = 0; i < 64; i++) msg.push_back(8'h00);
    run_msg("zero64", msg, 1'b0, 1'b0);
    n_cmp++;
    if (got_w.size() != 32 || got_w[16] !== 32'h80000000 || got_w[31] !== 32'h00000200) begin
      n_err++;
      $display("FAIL zero64 const: got n=%0d, required 32 words w16=80000000 w31=00000200",
               got_w.size());
    end
  endtask

  task automatic test_full_block_combined();
    byte_q_t msg;
    msg = {};
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    run_msg("full_comb", msg, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    byte_q_t msg;
    bit      found = 1'b0;
    msg = '{8'h47, 8'h6F, 8'h20, 8'h49, 8'h72, 8'h69, 8'h73, 8'h68, 8'h21};
    fork
      drive_msg(msg, 1'b0);
      begin
        word_ready_i = 1'b1;
        for (int c = 0; c < 400 && !found; c++) begin
          @(negedge clk_i);
          if (word_valid_o === 1'b1 && word_index_o === 4'd5) begin
            found = 1'b1;
            word_ready_i = 1'b0;
          end
        end
      end
    join
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL reset_mid reach: word_index=%0d, required 5 before reset", word_index_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    test_go_irish("after_reset", 1'b0);
  endtask

  task automatic test_back_to_back();
    byte_q_t msg;
    for (int m = 0; m < 2; m++) begin
      msg = {};
      for (int i = 0; i < 20 + 50 * m; i++) msg.push_back(8'($urandom));
      run_msg("b2b", msg, 1'b0, 1'(m));
    end
  endtask

  task automatic test_random();
    byte_q_t msg;
    int      len;
    for (int m = 0; m < 10; m++) begin
      msg = {};
      len = $urandom_range(0, 140);
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      run_msg("random", msg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_go_irish("go_irish", 1'b0);
    test_empty();
    test_56_bytes();
    test_64_zero();
    test_go_irish("backpressure", 1'b1);
    test_full_block_combined();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
